rom_loader: RTL and testbench

- Boot controller between the UART receiver and the instruction ROM write port on mother_board.
- Holds the CPU in reset and receives a framed program image byte-by-byte over UART. Assembles little-endian 32-bit instruction words and writes them to ROM from address 0.
- Verifies an XOR checksum, then releases the CPU.
- Supports reload while the CPU is halted, so benches and hosts can replace the program without touching the ROM array directly.

---
 rtl/rom_loader.sv | 208 ++++++++++++++++++++
 tb/tb_rom_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - UART boot loader: receives a framed image, writes ROM, checks XOR, releases the CPU
`timescale 1ns/1ps
module rom_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          TIMEOUT   = 100000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              cpu_halt,
    output logic              cpu_reset,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              loaded,
    output logic              error,
    output logic [ADDR_W:0]   load_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CW    = ADDR_W + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              loaded_q, loaded_d;
    logic              error_q, error_d;
    logic [CW-1:0]     load_count_q, load_count_d;
    logic [15:0]       n16;
    logic              timed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_SYNC;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            tmo_q        <= '0;
            cpu_reset_q  <= 1'b1;
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= '0;
            rom_wdata_q  <= '0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            tmo_q        <= tmo_d;
            cpu_reset_q  <= cpu_reset_d;
            rom_we_q     <= rom_we_d;
            rom_waddr_q  <= rom_waddr_d;
            rom_wdata_q  <= rom_wdata_d;
            loaded_q     <= loaded_d;
            error_q      <= error_d;
            load_count_q <= load_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        tmo_d        = tmo_q;
        cpu_reset_d  = cpu_reset_q;
        rom_we_d     = 1'b0;
        rom_waddr_d  = rom_waddr_q;
        rom_wdata_d  = rom_wdata_q;
        loaded_d     = loaded_q;
        error_d      = error_q;
        load_count_d = load_count_q;
        n16          = {rx_data, len_lo_q};
        timed        = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CHECK);

        if (timed) begin
            tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            S_SYNC: begin
                cpu_reset_d = 1'b1;
                loaded_d    = 1'b0;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN0;
                    error_d = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    if (int'(n16) > DEPTH) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        len_d      = CW'(n16);
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        xor_d      = '0;
                        state_d    = (n16 == 16'd0) ? S_CHECK : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    xor_d      = xor_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            rom_wdata_d = {rx_data, asm_q};
                            rom_waddr_d = word_idx_q[ADDR_W-1:0];
                            rom_we_d    = 1'b1;
                            word_idx_d  = word_idx_q + 1'b1;
                            if (word_idx_d == len_q) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == xor_q) begin
                        state_d      = S_RUN;
                        cpu_reset_d  = 1'b0;
                        loaded_d     = 1'b1;
                        load_count_d = len_q;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cpu_reset_d = 1'b0;
                // Reload is only honoured once the CPU has parked itself on a halt.
                if (rx_valid && cpu_halt && rx_data == SYNC_BYTE) begin
                    state_d     = S_LEN0;
                    cpu_reset_d = 1'b1;
                    loaded_d    = 1'b0;
                    tmo_d       = '0;
                end
            end
            default: begin
                error_d     = 1'b1;
                cpu_reset_d = 1'b1;
                loaded_d    = 1'b0;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN0;
                    error_d = 1'b0;
                    tmo_d   = '0;
                end
            end
        endcase

        if (timed && !rx_valid && tmo_q == TMO_LAST) begin
            state_d     = S_ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
            loaded_d    = 1'b0;
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign rom_we     = rom_we_q;
    assign rom_waddr  = rom_waddr_q;
    assign rom_wdata  = rom_wdata_q;
    assign loaded     = loaded_q;
    assign error      = error_q;
    assign load_count = load_count_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized frame-level checks of rom_loader against a byte/word reference model
`timescale 1ns/1ps
module tb_rom_loader;
    localparam int         ADDR_W = 8;
    localparam logic [7:0] SYNC   = 8'hA5;

    typedef logic [31:0] wq_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              cpu_halt = 1'b0;
    logic              cpu_reset, rom_we, loaded, error;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic [ADDR_W:0]   load_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [39:0] wr_q[$];

    rom_loader #(.ADDR_W(ADDR_W), .TIMEOUT(16), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .cpu_halt(cpu_halt), .cpu_reset(cpu_reset), .rom_we(rom_we),
        .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .loaded(loaded),
        .error(error), .load_count(load_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (rom_we) wr_q.push_back({rom_waddr, rom_wdata});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic wq_t rand_words(input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends header (optionally without sync) and data, checks the ROM writes, returns the correct CHK.
    task automatic send_frame(input wq_t words, input bit with_sync, output logic [7:0] chk);
        int n;
        logic [7:0] b;
        n   = words.size();
        chk = 8'h00;
        wr_q.delete();
        if (with_sync) send_byte(SYNC);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b   = words[i][8*k +: 8];
                chk = chk ^ b;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(b);
            end
        end
        n_cmp++;
        if (wr_q.size() !== n) begin
            n_bad++;
            $display("FAIL write_count got=%0d exp=%0d", wr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[i] !== {i[7:0], words[i]}) begin
                n_bad++;
                $display("FAIL write[%0d] got=%h exp=%h", i, wr_q[i], {i[7:0], words[i]});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
        n_cmp++; if (rom_we !== 1'b0) begin n_bad++; $display("FAIL reset_rom_we got=%b exp=0", rom_we); end
        n_cmp++; if (rom_waddr !== '0) begin n_bad++; $display("FAIL reset_rom_waddr got=%h exp=0", rom_waddr); end
        n_cmp++; if (rom_wdata !== '0) begin n_bad++; $display("FAIL reset_rom_wdata got=%h exp=0", rom_wdata); end
        n_cmp++; if (loaded !== 1'b0) begin n_bad++; $display("FAIL reset_loaded got=%b exp=0", loaded); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b exp=0", error); end
        n_cmp++; if (load_count !== '0) begin n_bad++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
        reset = 1'b0;
        send_byte(8'h3C);
        n_cmp++; if (cpu_reset !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL sync_ignore got=%b%b exp=10", cpu_reset, error); end
    endtask

    task automatic test_basic_load();
        wq_t w;
        logic [7:0] chk;
        w = '{32'h00101000, 32'h0000000A};
        send_frame(w, 1'b1, chk);
        n_cmp++; if (cpu_reset !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL basic_pre_chk got=%b%b exp=10", cpu_reset, loaded); end
        send_byte(chk);
        n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL basic_cpu_reset got=%b exp=0", cpu_reset); end
        n_cmp++; if (loaded !== 1'b1) begin n_bad++; $display("FAIL basic_loaded got=%b exp=1", loaded); end
        n_cmp++; if (load_count !== 9'd2) begin n_bad++; $display("FAIL basic_load_count got=%0d exp=2", load_count); end
        n_cmp++; if (rom_we !== 1'b0) begin n_bad++; $display("FAIL basic_rom_we_idle got=%b exp=0", rom_we); end
    endtask

    task automatic test_bad_checksum();
        wq_t w;
        logic [7:0] chk;
        logic [ADDR_W:0] prev;
        int n;
        prev = load_count;
        cpu_halt = 1'b1;
        w = '{32'h00101000, 32'h0000000A};
        send_frame(w, 1'b1, chk);
        send_byte(chk ^ 8'h01);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL badchk_error got=%b exp=1", error); end
        n_cmp++; if (cpu_reset !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL badchk_cpu got=%b%b exp=10", cpu_reset, loaded); end
        n_cmp++; if (load_count !== prev) begin n_bad++; $display("FAIL badchk_load_count got=%0d exp=%0d", load_count, prev); end
        n = $urandom_range(1, 8);
        w = rand_words(n);
        send_frame(w, 1'b1, chk);
        send_byte(chk);
        n_cmp++; if (error !== 1'b0 || loaded !== 1'b1 || cpu_reset !== 1'b0) begin n_bad++; $display("FAIL recover_flags got=%b%b%b exp=010", error, loaded, cpu_reset); end
        n_cmp++; if (load_count !== n[ADDR_W:0]) begin n_bad++; $display("FAIL recover_load_count got=%0d exp=%0d", load_count, n); end
    endtask

    task automatic test_zero_len();
        wq_t w;
        logic [7:0] chk;
        cpu_halt = 1'b1;
        w = {};
        send_frame(w, 1'b1, chk);
        send_byte(chk);
        n_cmp++; if (loaded !== 1'b1 || cpu_reset !== 1'b0) begin n_bad++; $display("FAIL zero_run got=%b%b exp=10", loaded, cpu_reset); end
        n_cmp++; if (load_count !== 9'd0) begin n_bad++; $display("FAIL zero_load_count got=%0d exp=0", load_count); end
    endtask

    task automatic test_oversize();
        cpu_halt = 1'b1;
        wr_q.delete();
        send_byte(SYNC);
        send_byte(8'h01);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL over_early_error got=%b exp=0", error); end
        send_byte(8'h01);
        n_cmp++; if (error !== 1'b1 || cpu_reset !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL over_error got=%b%b%b exp=110", error, cpu_reset, loaded); end
        send_byte(8'h55);
        n_cmp++; if (wr_q.size() !== 0) begin n_bad++; $display("FAIL over_writes got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_max_len();
        wq_t w;
        logic [7:0] chk;
        w = rand_words(256);
        send_frame(w, 1'b1, chk);
        send_byte(chk);
        n_cmp++; if (load_count !== 9'd256 || loaded !== 1'b1) begin n_bad++; $display("FAIL max_load got=%0d/%b exp=256/1", load_count, loaded); end
    endtask

    task automatic test_timeout();
        cpu_halt = 1'b1;
        wr_q.delete();
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (8) @(negedge clk);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL tmo_early got=%b exp=0", error); end
        repeat (8) @(negedge clk);
        n_cmp++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin n_bad++; $display("FAIL tmo_error got=%b%b exp=11", error, cpu_reset); end
        n_cmp++; if (wr_q.size() !== 0) begin n_bad++; $display("FAIL tmo_writes got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_run_ignore();
        wq_t w;
        logic [7:0] chk;
        cpu_halt = 1'b0;
        w = rand_words(1);
        send_frame(w, 1'b1, chk);
        send_byte(chk);
        wr_q.delete();
        send_byte(SYNC);
        send_byte(8'h01);
        n_cmp++; if (cpu_reset !== 1'b0 || loaded !== 1'b1 || wr_q.size() !== 0) begin n_bad++; $display("FAIL ignore_run got=%b%b/%0d exp=01/0", cpu_reset, loaded, wr_q.size()); end
        cpu_halt = 1'b1;
        send_byte(SYNC);
        n_cmp++; if (cpu_reset !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL reload_hold got=%b%b exp=10", cpu_reset, loaded); end
        w = rand_words(1);
        send_frame(w, 1'b0, chk);
        send_byte(chk);
        n_cmp++; if (cpu_reset !== 1'b0 || load_count !== 9'd1) begin n_bad++; $display("FAIL reload_run got=%b/%0d exp=0/1", cpu_reset, load_count); end
    endtask

    task automatic test_mid_reset();
        wq_t w;
        logic [7:0] chk;
        int n;
        cpu_halt = 1'b1;
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (cpu_reset !== 1'b1 || rom_we !== 1'b0 || loaded !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL mid_flags got=%b%b%b%b exp=1000", cpu_reset, rom_we, loaded, error); end
        n_cmp++; if (rom_waddr !== '0 || rom_wdata !== '0 || load_count !== '0) begin n_bad++; $display("FAIL mid_regs got=%h/%h/%0d exp=0/0/0", rom_waddr, rom_wdata, load_count); end
        cpu_halt = 1'b0;
        n = $urandom_range(2, 6);
        w = rand_words(n);
        send_frame(w, 1'b1, chk);
        send_byte(chk);
        n_cmp++; if (loaded !== 1'b1 || load_count !== n[ADDR_W:0]) begin n_bad++; $display("FAIL mid_reload got=%b/%0d exp=1/%0d", loaded, load_count, n); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_checksum();
        test_zero_len();
        test_oversize();
        test_max_len();
        test_timeout();
        test_run_ignore();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
